// File: rtl/sha_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha_sched_pkg
// Purpose  : Shared types and constants for the SHA message scheduler:
//            scheduler state encoding, SHA type codes, width helper.
// Revision : 1.0 - initial release
// ============================================================================
package sha_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } sched_state_t;

  localparam logic [1:0] SHA256 = 2'b00;
  localparam logic [1:0] SHA224 = 2'b01;
  localparam logic [1:0] SHA384 = 2'b10;
  localparam logic [1:0] SHA512 = 2'b11;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha_msg_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational masked round-robin arbiter. Requests strictly above
//            the pointer win first; otherwise the lowest request wins.
//            The pointer register lives in the parent.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import sha_sched_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = clog2_min1(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [NUM_SRC-1:0]  o_gnt,
  output logic [ID_WIDTH-1:0] o_gnt_id
);

  logic [NUM_SRC-1:0] w_masked;
  logic [NUM_SRC-1:0] w_sel;
  logic               w_found;

  // Mask off requests at or below the last owner, fall back to the full set
  // when nothing above it is pending, then pick the lowest set bit.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i > int'(i_ptr)) w_masked[i] = i_req[i];
    end
    w_sel    = (|w_masked) ? w_masked : i_req;
    o_gnt    = '0;
    o_gnt_id = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_sel[i] && !w_found) begin
        w_found  = 1'b1;
        o_gnt[i] = 1'b1;
        o_gnt_id = ID_WIDTH'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sha_msg_scheduler
// Purpose  : Shares one padder/hash pipeline between NUM_SRC AXI-Stream
//            sources. Grants one whole message at a time round-robin, holds
//            the owner's sha_type and en until the engine reports done, and
//            aborts a stuck drain with a sticky timeout error.
// Revision : 1.0 - initial release
// ============================================================================
module sha_msg_scheduler
  import sha_sched_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DATA_WIDTH     = 512,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int SRC_ID_WIDTH   = clog2_min1(NUM_SRC),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          axi_aclk,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC*2-1:0]          s_sha_type,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [1:0]                    sha_type,
  output logic                          en,
  input  logic                          eng_done,
  output logic [SRC_ID_WIDTH-1:0]       grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int                    WD_WIDTH = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [WD_WIDTH-1:0]   WD_LAST  = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  sched_state_t              r_state;
  sched_state_t              w_state_nxt;
  logic [SRC_ID_WIDTH-1:0]   r_ptr;
  logic [SRC_ID_WIDTH-1:0]   r_grant_id;
  logic [1:0]                r_sha_type;
  logic                      r_en;
  logic                      r_timeout_err;
  logic [WD_WIDTH-1:0]       r_wd_cnt;

  logic [NUM_SRC-1:0]        w_arb_gnt;
  logic [SRC_ID_WIDTH-1:0]   w_arb_id;
  logic [1:0]                w_arb_type;
  logic                      w_src_valid;
  logic                      w_src_last;
  logic                      w_last_hs;
  logic                      w_grant_take;
  logic                      w_release;
  logic                      w_set_err;

  rr_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (SRC_ID_WIDTH)
  ) u_arb (
    .i_req    (s_axis_tvalid),
    .i_ptr    (r_ptr),
    .o_gnt    (w_arb_gnt),
    .o_gnt_id (w_arb_id)
  );

  // One-hot select of the winning source's hash type, sampled at grant.
  always_comb begin
    w_arb_type = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_arb_gnt[i]) w_arb_type = w_arb_type | s_sha_type[i*2 +: 2];
    end
  end

  // Pass-through mux from the current owner; only STREAM exposes it.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    w_src_valid   = 1'b0;
    w_src_last    = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant_id == SRC_ID_WIDTH'(i)) begin
        m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        w_src_valid      = s_axis_tvalid[i];
        w_src_last       = s_axis_tlast[i];
        s_axis_tready[i] = (r_state == ST_STREAM) && m_axis_tready;
      end
    end
    m_axis_tvalid = (r_state == ST_STREAM) && w_src_valid;
    m_axis_tlast  = (r_state == ST_STREAM) && w_src_last;
  end

  assign w_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Next-state logic; eng_done beats the watchdog when both land together.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_take = 1'b0;
    w_release    = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          w_state_nxt  = ST_STREAM;
          w_grant_take = 1'b1;
        end
      end
      ST_STREAM: begin
        if (w_last_hs) w_state_nxt = ST_DRAIN;
        if (eng_done)  w_set_err   = 1'b1;
      end
      ST_DRAIN: begin
        if (eng_done) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end else if (r_wd_cnt == WD_LAST) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
          w_set_err   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axi_aclk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant bookkeeping, enable, sticky error and the drain watchdog.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      r_ptr         <= SRC_ID_WIDTH'(NUM_SRC - 1);
      r_grant_id    <= '0;
      r_sha_type    <= '0;
      r_en          <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wd_cnt      <= '0;
    end else begin
      if (w_grant_take) begin
        r_grant_id <= w_arb_id;
        r_ptr      <= w_arb_id;
        r_sha_type <= w_arb_type;
        r_en       <= 1'b1;
      end else if (w_release) begin
        r_en <= 1'b0;
      end
      if (w_set_err) r_timeout_err <= 1'b1;
      // Counter only advances while staying in DRAIN, so it stops at WD_LAST.
      if (r_state == ST_DRAIN && w_state_nxt == ST_DRAIN) r_wd_cnt <= r_wd_cnt + 1'b1;
      else                                                r_wd_cnt <= '0;
    end
  end

  assign sha_type    = r_sha_type;
  assign en          = r_en;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_sha_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_msg_scheduler
// Purpose  : Scoreboard bench for sha_msg_scheduler. Stimulus queues source
//            beats and pushes expected output beats; a monitor compares every
//            master-side handshake against the expected queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha_msg_scheduler;

  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int KW  = DW / 8;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic              axi_aclk = 1'b0;
  logic              reset    = 1'b1;
  logic [NS*DW-1:0]  s_axis_tdata;
  logic [NS*KW-1:0]  s_axis_tkeep;
  logic [NS-1:0]     s_axis_tvalid;
  logic [NS-1:0]     s_axis_tlast;
  logic [NS-1:0]     s_axis_tready;
  logic [NS*2-1:0]   s_sha_type;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [1:0]        sha_type;
  logic              en;
  logic              eng_done;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              timeout_err;

  always #5 axi_aclk = ~axi_aclk;

  sha_msg_scheduler #(
    .NUM_SRC        (NS),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .axi_aclk      (axi_aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .s_sha_type    (s_sha_type),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .sha_type      (sha_type),
    .en            (en),
    .eng_done      (eng_done),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          gap;
  } beat_t;

  typedef struct {
    logic [DW-1:0]  d;
    logic [KW-1:0]  k;
    logic           l;
    logic [IDW-1:0] id;
    logic [1:0]     ty;
  } exp_t;

  beat_t src_q [NS][$];
  exp_t  exp_q [$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    n_beats = 0;
  int    n_last  = 0;
  int    msg_tag = 0;
  logic  toggle_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Source driver: retire accepted beats and one-cycle gaps, present next.
  initial begin
    logic [NS-1:0] hs;
    beat_t b;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    forever begin
      @(negedge axi_aclk);
      hs = reset ? '0 : (s_axis_tvalid & s_axis_tready);
      @(posedge axi_aclk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (reset) begin
          src_q[i].delete();
        end else if (src_q[i].size() > 0) begin
          b = src_q[i][0];
          if (b.gap || hs[i]) void'(src_q[i].pop_front());
        end
        if (src_q[i].size() > 0 && !src_q[i][0].gap) begin
          b = src_q[i][0];
          s_axis_tvalid[i]          = 1'b1;
          s_axis_tdata[i*DW +: DW]  = b.d;
          s_axis_tkeep[i*KW +: KW]  = b.k;
          s_axis_tlast[i]           = b.l;
        end else begin
          s_axis_tvalid[i] = 1'b0;
          s_axis_tlast[i]  = 1'b0;
        end
      end
    end
  end

  // Padder-side ready: steady high, or toggling every cycle when asked.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge axi_aclk);
      #1;
      m_axis_tready = toggle_rdy ? ~m_axis_tready : 1'b1;
    end
  end

  // Monitor: ready exclusivity and scoreboard comparison of each beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge axi_aclk);
      if (!reset) begin
        if (s_axis_tready != '0)
          chk("tready_only_granted", 64'(s_axis_tready & ~(NS'(1) << grant_id)), 64'd0);
        if (m_axis_tvalid && m_axis_tready) begin
          n_beats++;
          if (m_axis_tlast) n_last++;
          chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", 64'({en, sha_type, grant_id, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
                        64'({1'b1, e.ty, e.id, e.l, e.k, e.d}));
          end
        end
      end
    end
  end

  task automatic add_msg(input int src, input int nb, input int gap_at, input int n_exp,
                         input logic [1:0] ty);
    beat_t b;
    exp_t  e;
    s_sha_type[src*2 +: 2] = ty;
    for (int j = 0; j < nb; j++) begin
      if (j == gap_at) begin
        b.gap = 1'b1; b.d = '0; b.k = '0; b.l = 1'b0;
        src_q[src].push_back(b);
        src_q[src].push_back(b);
      end
      b.gap = 1'b0;
      b.d   = {8'hC0 + 8'(msg_tag), 8'(src), 8'(j), 8'h5A};
      b.k   = (j == nb - 1) ? 4'b0111 : 4'hF;
      b.l   = (j == nb - 1);
      src_q[src].push_back(b);
      if (j < n_exp) begin
        e.d = b.d; e.k = b.k; e.l = b.l; e.id = IDW'(src); e.ty = ty;
        exp_q.push_back(e);
      end
    end
    msg_tag++;
  endtask

  task automatic wait_last(input int target);
    int cyc = 0;
    while (n_last < target && cyc < 300) begin
      @(posedge axi_aclk);
      #2;
      cyc++;
    end
    chk("tlast_seen", 64'(n_last >= target), 64'd1);
  endtask

  // Engine model: hold DRAIN for `delay` cycles while checking held state, then pulse done.
  task automatic eng_after(input int target, input int delay, input logic [1:0] ty);
    wait_last(target);
    repeat (delay) begin
      @(negedge axi_aclk);
      chk("drain_hold", 64'({en, busy, m_axis_tvalid, s_axis_tready, sha_type}),
                        64'({1'b1, 1'b1, 1'b0, 4'b0000, ty}));
    end
    @(posedge axi_aclk); #2; eng_done = 1'b1;
    @(posedge axi_aclk); #2; eng_done = 1'b0;
    @(negedge axi_aclk);
    chk("release", 64'({en, busy}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int t;
    int b0;
    int cyc;
    eng_done   = 1'b0;
    s_sha_type = '0;

    // Reset state
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("reset_state", 64'({en, busy, timeout_err, m_axis_tvalid, s_axis_tready, sha_type, grant_id}), 64'd0);
    @(posedge axi_aclk); #2;
    reset = 1'b0;

    // Single source, 3 beats, done 10 cycles after tlast
    t = n_last;
    add_msg(0, 3, -1, 3, 2'b01);
    eng_after(t + 1, 10, 2'b01);

    // Sources 1 and 3 at reset release; source 1 re-requests: order 1,3,1
    @(posedge axi_aclk); #2; reset = 1'b1;
    repeat (2) @(posedge axi_aclk);
    #2; reset = 1'b0;
    t = n_last;
    add_msg(1, 2, -1, 2, 2'b00);
    add_msg(3, 2, -1, 2, 2'b11);
    add_msg(1, 3, -1, 3, 2'b00);
    eng_after(t + 1, 2, 2'b00);
    eng_after(t + 2, 2, 2'b11);
    eng_after(t + 3, 2, 2'b00);

    // SHA512 owner with a competing SHA256 requester
    t = n_last;
    add_msg(2, 3, -1, 3, 2'b11);
    add_msg(0, 2, -1, 2, 2'b00);
    eng_after(t + 1, 4, 2'b11);
    eng_after(t + 2, 2, 2'b00);

    // Toggling ready with a source gap mid-message
    t = n_last;
    toggle_rdy = 1'b1;
    add_msg(1, 5, 2, 5, 2'b01);
    wait_last(t + 1);
    toggle_rdy = 1'b0;
    eng_after(t + 1, 3, 2'b01);
    chk("tlast_once", 64'(n_last), 64'(t + 1));

    // Watchdog: no eng_done, abort after 16 DRAIN cycles
    t = n_last;
    add_msg(3, 2, -1, 2, 2'b10);
    wait_last(t + 1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge axi_aclk);
      if (k == 1 || k == TO) chk("wd_drain", 64'({busy, en, timeout_err}), 64'(3'b110));
    end
    @(negedge axi_aclk);
    chk("wd_expire", 64'({busy, en, timeout_err}), 64'(3'b001));
    t = n_last;
    add_msg(0, 1, -1, 1, 2'b01);
    eng_after(t + 1, 2, 2'b01);
    chk("timeout_sticky", 64'(timeout_err), 64'd1);

    // Reset on the second beat of a 4-beat message
    b0 = n_beats;
    cyc = 0;
    add_msg(1, 4, -1, 1, 2'b10);
    while (n_beats < b0 + 1 && cyc < 300) begin
      @(posedge axi_aclk); #2;
      cyc++;
    end
    chk("first_beat_before_reset", 64'(n_beats), 64'(b0 + 1));
    reset = 1'b1;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("reset_mid_msg", 64'({en, busy, timeout_err, m_axis_tvalid, s_axis_tready, sha_type, grant_id}), 64'd0);
    @(posedge axi_aclk); #2;
    reset = 1'b0;
    t = n_last;
    add_msg(0, 1, -1, 1, 2'b01);
    add_msg(2, 1, -1, 1, 2'b11);
    eng_after(t + 1, 2, 2'b01);
    eng_after(t + 2, 2, 2'b11);

    @(posedge axi_aclk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
